// File: rtl/r_fifo_pkg.sv
// Shared constants for the R-channel burst FIFO: AXI response codes and
// the pointer-width helper used to size the storage and counters.
package r_fifo_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Number of address bits needed to index a power-of-two depth.
    function automatic int clog2_depth(input int depth);
        int bits;
        bits = 0;
        while ((1 << bits) < depth) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/r_fifo_mem.sv
// Beat storage for the R-channel FIFO: synchronous write, asynchronous read,
// no reset so the array maps cleanly onto distributed RAM.
module r_fifo_mem #(
    parameter int WIDTH = 71,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/r_burst_fifo.sv
// AXI R-channel beat buffer with optional store-and-forward by burst.
// Tracks occupancy, complete bursts held and a sticky error-response flag.
module r_burst_fifo
    import r_fifo_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2,
    parameter int DEPTH      = 16,
    parameter int STORE_FWD  = 0
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    r_in_valid,
    output logic                    r_in_ready,
    input  logic [ID_WIDTH-1:0]     r_in_id,
    input  logic [DATA_WIDTH-1:0]   r_in_data,
    input  logic [RESP_WIDTH-1:0]   r_in_resp,
    input  logic                    r_in_last,

    output logic                    r_out_valid,
    input  logic                    r_out_ready,
    output logic [ID_WIDTH-1:0]     r_out_id,
    output logic [DATA_WIDTH-1:0]   r_out_data,
    output logic [RESP_WIDTH-1:0]   r_out_resp,
    output logic                    r_out_last,

    output logic [$clog2(DEPTH):0]  occupancy,
    output logic [$clog2(DEPTH):0]  bursts_held,
    output logic                    err_seen,
    input  logic                    err_clr
);

    localparam int AW    = clog2_depth(DEPTH);
    localparam int CW    = AW + 1;
    localparam int WIDTH = ID_WIDTH + DATA_WIDTH + RESP_WIDTH + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam bit SF = (STORE_FWD != 0);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] bursts_q, bursts_d;
    logic          drain_q, drain_d;
    logic          err_q, err_d;

    logic [WIDTH-1:0]      memWdata;
    logic [WIDTH-1:0]      memRdata;
    logic [ID_WIDTH-1:0]   headId;
    logic [DATA_WIDTH-1:0] headData;
    logic [RESP_WIDTH-1:0] headResp;
    logic                  headLast;

    logic isFull;
    logic hasData;
    logic releaseOk;
    logic push;
    logic pop;
    logic pushLast;
    logic popLast;

    assign memWdata = {r_in_id, r_in_data, r_in_resp, r_in_last};
    assign {headId, headData, headResp, headLast} = memRdata;

    r_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (memWdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (memRdata)
    );

    // A full buffer refuses input even when a pop frees a slot this cycle.
    assign isFull    = (occ_q == FULL_CNT);
    assign hasData   = (occ_q != '0);
    assign releaseOk = SF ? ((bursts_q != '0) | isFull | drain_q) : 1'b1;

    assign r_in_ready  = !rst & !isFull;
    assign r_out_valid = !rst & hasData & releaseOk;

    assign push     = r_in_valid & r_in_ready;
    assign pop      = r_out_valid & r_out_ready;
    assign pushLast = push & r_in_last;
    assign popLast  = pop & headLast;

    assign r_out_id    = r_out_valid ? headId   : '0;
    assign r_out_data  = r_out_valid ? headData : '0;
    assign r_out_resp  = r_out_valid ? headResp : '0;
    assign r_out_last  = r_out_valid ? headLast : 1'b0;

    assign occupancy   = occ_q;
    assign bursts_held = bursts_q;
    assign err_seen    = err_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        bursts_d = bursts_q;
        drain_d  = drain_q;
        err_d    = err_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        case ({pushLast, popLast})
            2'b10:   bursts_d = bursts_q + 1'b1;
            2'b01:   bursts_d = bursts_q - 1'b1;
            default: bursts_d = bursts_q;
        endcase

        // A burst larger than the buffer would never complete; fall back to cut-through until its last beat leaves.
        if (isFull && (bursts_q == '0)) begin
            drain_d = 1'b1;
        end else if (popLast) begin
            drain_d = 1'b0;
        end

        if (pop && headResp[1]) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            bursts_q <= '0;
            drain_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            bursts_q <= bursts_d;
            drain_q  <= drain_d;
            err_q    <= err_d;
        end
    end

endmodule
